// File: rtl/score_sequencer_if.sv
// Event/awarder/score bundle for score_sequencer.
// The slave side is the sequencer; the master side is everything around it:
// the event producer, the point-awarder stub and the score display.
interface score_sequencer_if #(
   parameter int SCORE_W = 14
);
   logic               clear;
   logic               evt_valid;
   logic               evt_ready;
   logic               evt_stacked;
   logic [1:0]         evt_blocks;
   logic [2:0]         evt_height;
   logic               pa_stacked;
   logic [1:0]         pa_blocks;
   logic [2:0]         pa_height;
   logic [4:0]         pa_points;
   logic [SCORE_W-1:0] score;
   logic [2:0]         streak;
   logic [2:0]         misses;
   logic               score_upd;
   logic               game_over;

   modport slave (
      input  clear, evt_valid, evt_stacked, evt_blocks, evt_height, pa_points,
      output evt_ready, pa_stacked, pa_blocks, pa_height,
             score, streak, misses, score_upd, game_over
   );

   modport master (
      output clear, evt_valid, evt_stacked, evt_blocks, evt_height, pa_points,
      input  evt_ready, pa_stacked, pa_blocks, pa_height,
             score, streak, misses, score_upd, game_over
   );
endinterface

// File: rtl/score_sequencer.sv
// Score sequencer for the stacking game.
// Each accepted event is driven onto the point-awarder inputs. The awarder
// result is sampled after one settle cycle. The score, streak and miss
// counters are then updated in a fourth cycle.
// Timeline: accept (E0) -> LOAD -> SAMPLE (E2 samples points) -> ACCUM (E3 updates).
module score_sequencer #(
   parameter int SCORE_W      = 14,
   parameter int COMBO_THRESH = 3,
   parameter int MAX_MISS     = 3
) (
   input logic               clk,
   input logic               rst,
   score_sequencer_if.slave  sq
);
   typedef enum logic [1:0] {IDLE, LOAD, SAMPLE, ACCUM} state_t;

   localparam logic [2:0] MISS_MAX = 3'(MAX_MISS);

   state_t             state_q;
   logic               pa_stacked_q;
   logic [1:0]         pa_blocks_q;
   logic [2:0]         pa_height_q;
   logic [4:0]         pts_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         streak_q, streak_d;
   logic [2:0]         misses_q, misses_d;
   logic               over_q, over_d;
   logic               upd_q;
   logic [5:0]         add;
   logic [SCORE_W:0]   sum;
   logic               accept;

   // Ready is also gated by rst, so it stays low while reset is held.
   assign sq.evt_ready = (state_q == IDLE) && !over_q && !sq.clear && !rst;
   assign accept       = sq.evt_valid && sq.evt_ready;

   // Next score/streak/miss values, applied at the end of ACCUM.
   always_comb begin
      streak_d = streak_q;
      misses_d = misses_q;
      score_d  = score_q;
      over_d   = over_q;
      add      = '0;
      sum      = '0;
      if (pa_stacked_q) begin
         streak_d = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
         add      = (32'(streak_d) >= COMBO_THRESH) ? {pts_q, 1'b0} : {1'b0, pts_q};
         // The extra sum bit catches overflow so the score saturates instead of wrapping.
         sum      = {1'b0, score_q} + (SCORE_W+1)'(add);
         score_d  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end else begin
         streak_d = '0;
         misses_d = (misses_q == MISS_MAX) ? misses_q : misses_q + 3'd1;
         over_d   = over_q | (misses_d == MISS_MAX);
      end
   end

   // Sequencer FSM plus all registered outputs. Priority: rst, then clear, then normal flow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pa_stacked_q <= 1'b0;
         pa_blocks_q  <= '0;
         pa_height_q  <= '0;
         pts_q        <= '0;
         score_q      <= '0;
         streak_q     <= '0;
         misses_q     <= '0;
         over_q       <= 1'b0;
         upd_q        <= 1'b0;
      end else if (sq.clear) begin
         state_q      <= IDLE;
         pa_stacked_q <= 1'b0;
         pa_blocks_q  <= '0;
         pa_height_q  <= '0;
         pts_q        <= '0;
         score_q      <= '0;
         streak_q     <= '0;
         misses_q     <= '0;
         over_q       <= 1'b0;
         upd_q        <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The pa_* outputs hold their last values until the next accept.
               if (accept) begin
                  pa_stacked_q <= sq.evt_stacked;
                  pa_blocks_q  <= sq.evt_blocks;
                  pa_height_q  <= sq.evt_height;
                  state_q      <= LOAD;
               end
            end
            LOAD:   state_q <= SAMPLE;
            SAMPLE: begin
               pts_q   <= sq.pa_points;
               state_q <= ACCUM;
            end
            ACCUM: begin
               score_q  <= score_d;
               streak_q <= streak_d;
               misses_q <= misses_d;
               over_q   <= over_d;
               upd_q    <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sq.pa_stacked = pa_stacked_q;
   assign sq.pa_blocks  = pa_blocks_q;
   assign sq.pa_height  = pa_height_q;
   assign sq.score      = score_q;
   assign sq.streak     = streak_q;
   assign sq.misses     = misses_q;
   assign sq.score_upd  = upd_q;
   assign sq.game_over  = over_q;
endmodule

// File: tb/tb_score_sequencer.sv
// Scoreboard bench for score_sequencer. Expected score, streak and misses
// come from a small reference model and are queued at accept time. They are
// popped and compared on every score_upd pulse.
module tb_score_sequencer;
   localparam int SCORE_W = 14;
   localparam int MAXS    = (1 << SCORE_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   typedef struct {
      int score;
      int streak;
      int misses;
      int over;
      int acc;
   } exp_t;
   exp_t sb[$];

   int m_score = 0, m_streak = 0, m_misses = 0, m_over = 0;

   score_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

   score_sequencer #(.SCORE_W(SCORE_W), .COMBO_THRESH(3), .MAX_MISS(3)) dut (
      .clk (clk),
      .rst (rst),
      .sq  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Reference model step; acc is the cycle count just after the accept edge.
   task automatic push_exp(input bit st, input int p, input int acc);
      int add;
      exp_t e;
      if (st) begin
         m_streak = (m_streak == 7) ? 7 : m_streak + 1;
         add      = (m_streak >= 3) ? 2 * p : p;
         m_score  = (m_score + add > MAXS) ? MAXS : m_score + add;
      end else begin
         m_streak = 0;
         if (m_misses < 3) m_misses++;
         if (m_misses == 3) m_over = 1;
      end
      e.score = m_score; e.streak = m_streak; e.misses = m_misses;
      e.over = m_over; e.acc = acc;
      sb.push_back(e);
   endtask

   task automatic model_zero();
      m_score = 0; m_streak = 0; m_misses = 0; m_over = 0;
      sb.delete();
   endtask

   // Score-update monitor.
   always @(negedge clk) begin
      if (!rst && bus.score_upd) begin
         if (sb.size() == 0) chk("spurious_upd", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("score",     int'(bus.score),     e.score);
            chk("streak",    int'(bus.streak),    e.streak);
            chk("misses",    int'(bus.misses),    e.misses);
            chk("game_over", int'(bus.game_over), e.over);
            chk("latency",   cyc - e.acc,         3);
         end
      end
   end

   // Present an event, wait for its accept, and check the pa_* drive one edge later.
   task automatic send(input bit st, input logic [1:0] b, input logic [2:0] h,
                       input logic [4:0] p);
      int n = 0;
      @(negedge clk);
      bus.evt_valid = 1'b1; bus.evt_stacked = st;
      bus.evt_blocks = b;   bus.evt_height = h;
      while (!bus.evt_ready) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            chk("accept_timeout", 0, 1);
            bus.evt_valid = 1'b0;
            return;
         end
      end
      bus.pa_points = p;
      @(posedge clk);
      #1;
      push_exp(st, int'(p), cyc);
      chk("pa_stacked", int'(bus.pa_stacked), int'(st));
      chk("pa_blocks",  int'(bus.pa_blocks),  int'(b));
      chk("pa_height",  int'(bus.pa_height),  int'(h));
      @(negedge clk);
      bus.evt_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_zero();
      #1;
   endtask

   initial begin
      bus.clear = 1'b0; bus.evt_valid = 1'b0; bus.evt_stacked = 1'b0;
      bus.evt_blocks = '0; bus.evt_height = '0; bus.pa_points = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_ready", int'(bus.evt_ready), 0);
      chk("rst_score", int'(bus.score), 0);
      chk("rst_pa",    int'({bus.pa_stacked, bus.pa_blocks, bus.pa_height}), 0);
      chk("rst_upd",   int'(bus.score_upd), 0);
      chk("rst_over",  int'(bus.game_over), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(bus.evt_ready), 1);

      // Single hit.
      send(1'b1, 2'd1, 3'd3, 5'd12);
      drain();
      chk("single_score", int'(bus.score), 12);

      // Combo: 10, 20, 40, then a doubled 31 gives 102.
      do_clear();
      for (int i = 0; i < 3; i++) send(1'b1, 2'd2, 3'd1, 5'd10);
      send(1'b1, 2'd3, 3'd7, 5'd31);
      drain();
      chk("combo_score", int'(bus.score), 102);

      // Misses lead to game over.
      do_clear();
      send(1'b1, 2'd1, 3'd1, 5'd5);
      for (int i = 0; i < 3; i++) send(1'b0, 2'd0, 3'd2, 5'd20);
      drain();
      chk("go_over",  int'(bus.game_over), 1);
      chk("go_ready", int'(bus.evt_ready), 0);
      chk("go_score", int'(bus.score), 5);
      bus.evt_valid = 1'b1; bus.evt_stacked = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("go_ignored", int'(bus.evt_ready), 0);
      end
      bus.evt_valid = 1'b0;
      chk("go_score_hold", int'(bus.score), 5);

      // Back-pressure: valid held high gives one accept every 4 clocks.
      do_clear();
      chk("clear_over", int'(bus.game_over), 0);
      begin
         int acc = 0;
         bus.evt_stacked = 1'b1; bus.evt_blocks = 2'd1; bus.evt_height = 3'd1;
         bus.pa_points = 5'd1; bus.evt_valid = 1'b1;
         for (int i = 0; i < 16; i++) begin
            chk("bp_ready", int'(bus.evt_ready), int'(i % 4 == 0));
            if (bus.evt_ready) begin
               acc++;
               push_exp(1'b1, 1, cyc + 1);
            end
            @(negedge clk);
         end
         bus.evt_valid = 1'b0;
         chk("bp_accepts", acc, 4);
         drain();
      end

      // Clear during SAMPLE aborts the event.
      send(1'b1, 2'd1, 3'd1, 5'd9);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_zero();
      #1;
      chk("clr_upd",    int'(bus.score_upd), 0);
      chk("clr_score",  int'(bus.score), 0);
      chk("clr_streak", int'(bus.streak), 0);
      chk("clr_misses", int'(bus.misses), 0);
      chk("clr_ready",  int'(bus.evt_ready), 1);
      chk("clr_pa",     int'({bus.pa_stacked, bus.pa_blocks, bus.pa_height}), 0);
      repeat (4) @(negedge clk);

      // Reset pulse during ACCUM.
      send(1'b1, 2'd1, 3'd1, 5'd9);
      drain();
      send(1'b0, 2'd2, 3'd2, 5'd3);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_score",  int'(bus.score), 0);
      chk("arst_misses", int'(bus.misses), 0);
      chk("arst_pa",     int'({bus.pa_stacked, bus.pa_blocks, bus.pa_height}), 0);
      chk("arst_ready",  int'(bus.evt_ready), 0);
      model_zero();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("arst_noupd", sb.size(), 0);

      // Saturation: repeated doubled 31s pin the score at its maximum.
      for (int i = 0; i < 400 && m_score < MAXS; i++) send(1'b1, 2'd3, 3'd7, 5'd31);
      send(1'b1, 2'd3, 3'd7, 5'd31);
      drain();
      chk("sat_score", int'(bus.score), MAXS);
      chk("sat_streak", int'(bus.streak), 7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
